// File: rtl/aud_sram_sched.sv
// rtl/aud_sram_sched.sv - audio key sequencer and SRAM port owner (recorder writes / DSP reads)
// Optional one-shot playback: define AUD_SCHED_AUTOSTOP_EN.
module aud_sram_sched #(
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = {ADDR_W{1'b1}},
  parameter int                TURN_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_rec_we,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  input  logic [ADDR_W-1:0] i_dsp_addr,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic [ADDR_W-1:0] o_stop_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic [2:0]        o_state
);

  localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TURN   = 3'd1,
    ST_REC    = 3'd2,
    ST_REC_P  = 3'd3,
    ST_PLAY   = 3'd4,
    ST_PLAY_P = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              tgt_rec_q, tgt_rec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              has_rec_q, has_rec_d;
  logic              rec_wr_q, rec_wr_d;
  logic [ADDR_W-1:0] stop_addr_q, stop_addr_d;
  logic              rec_start_q, rec_start_d;
  logic              rec_pause_q, rec_pause_d;
  logic              dsp_start_q, dsp_start_d;
  logic              dsp_pause_q, dsp_pause_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              wr_acc;
`ifdef AUD_SCHED_AUTOSTOP_EN
  logic              match_q, match_d;
  logic              match_now;
`endif

  always_comb begin
    state_d      = state_q;
    tgt_rec_d    = tgt_rec_q;
    cnt_d        = cnt_q;
    has_rec_d    = has_rec_q;
    rec_wr_d     = rec_wr_q;
    stop_addr_d  = stop_addr_q;
    rec_start_d  = 1'b0;
    dsp_start_d  = 1'b0;
    dsp_pause_d  = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    we_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    wr_acc       = (state_q == ST_REC) && i_rec_we;
`ifdef AUD_SCHED_AUTOSTOP_EN
    match_now    = (state_q == ST_PLAY) && (i_dsp_addr == stop_addr_q);
    match_d      = match_now;
`endif

    // While recording, sram_addr_q always holds the most recent accepted write address.
    if (wr_acc) begin
      sram_addr_d  = i_rec_addr;
      sram_wdata_d = i_rec_data;
      we_n_d       = 1'b0;
      rec_wr_d     = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!i_key_stop && !i_key_pause) begin
          if (i_key_rec) begin
            state_d   = ST_TURN;
            tgt_rec_d = 1'b1;
            cnt_d     = '0;
          end else if (i_key_play && has_rec_q) begin
            state_d   = ST_TURN;
            tgt_rec_d = 1'b0;
            cnt_d     = '0;
          end
        end
      end
      ST_TURN: begin
        if (i_key_stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TURN_LAST) begin
          if (tgt_rec_q) begin
            state_d     = ST_REC;
            rec_start_d = 1'b1;
            rec_wr_d    = 1'b0;
          end else begin
            state_d     = ST_PLAY;
            dsp_start_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REC, ST_REC_P: begin
        if (i_key_stop || (wr_acc && i_rec_addr == MAX_ADDR)) begin
          state_d = ST_IDLE;
          if (wr_acc || rec_wr_q) begin
            has_rec_d   = 1'b1;
            stop_addr_d = wr_acc ? i_rec_addr : sram_addr_q;
          end
        end else if (i_key_pause) begin
          state_d = (state_q == ST_REC) ? ST_REC_P : ST_REC;
        end
      end
      ST_PLAY: begin
        if (i_key_stop) begin
          state_d = ST_IDLE;
        end else if (i_key_pause) begin
          state_d     = ST_PLAY_P;
          dsp_pause_d = 1'b1;
        end
`ifdef AUD_SCHED_AUTOSTOP_EN
        else if (match_now && match_q) begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_PLAY_P: begin
        // A paused DSP stopped here is re-armed by its next start pulse.
        if (i_key_stop) begin
          state_d = ST_IDLE;
        end else if (i_key_pause) begin
          state_d     = ST_PLAY;
          dsp_pause_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read enable tracks the next state so it is live in the first PLAY cycle and drops on stop.
    if (state_d == ST_PLAY || state_d == ST_PLAY_P) begin
      sram_addr_d = i_dsp_addr;
      oe_n_d      = 1'b0;
    end
    rec_pause_d = (state_d == ST_REC_P);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      tgt_rec_q    <= 1'b0;
      cnt_q        <= '0;
      has_rec_q    <= 1'b0;
      rec_wr_q     <= 1'b0;
      stop_addr_q  <= '0;
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      dsp_start_q  <= 1'b0;
      dsp_pause_q  <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
`ifdef AUD_SCHED_AUTOSTOP_EN
      match_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tgt_rec_q    <= tgt_rec_d;
      cnt_q        <= cnt_d;
      has_rec_q    <= has_rec_d;
      rec_wr_q     <= rec_wr_d;
      stop_addr_q  <= stop_addr_d;
      rec_start_q  <= rec_start_d;
      rec_pause_q  <= rec_pause_d;
      dsp_start_q  <= dsp_start_d;
      dsp_pause_q  <= dsp_pause_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
`ifdef AUD_SCHED_AUTOSTOP_EN
      match_q      <= match_d;
`endif
    end
  end

  assign o_rec_start  = rec_start_q;
  assign o_rec_pause  = rec_pause_q;
  assign o_dsp_start  = dsp_start_q;
  assign o_dsp_pause  = dsp_pause_q;
  assign o_stop_addr  = stop_addr_q;
  assign o_sram_addr  = sram_addr_q;
  assign o_sram_wdata = sram_wdata_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_aud_sram_sched.sv
// tb/tb_aud_sram_sched.sv - directed bench for aud_sram_sched with SRAM write scoreboard
module tb_aud_sram_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_rec, key_play, key_pause, key_stop;
  logic        rec_we;
  logic [19:0] rec_addr, dsp_addr;
  logic [15:0] rec_data;
  logic        rec_start, rec_pause, dsp_start, dsp_pause;
  logic [19:0] stop_addr, sram_addr;
  logic [15:0] sram_wdata;
  logic        we_n, oe_n;
  logic [2:0]  state;

  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  n_rec_start = 0;
  int  n_dsp_start = 0;
  int  n_dsp_pause = 0;
  int  n_strobe = 0;

  always #5 clk = ~clk;

  aud_sram_sched dut (
    .i_clk(clk), .i_rst(rst),
    .i_key_rec(key_rec), .i_key_play(key_play), .i_key_pause(key_pause), .i_key_stop(key_stop),
    .i_rec_we(rec_we), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .i_dsp_addr(dsp_addr),
    .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause),
    .o_stop_addr(stop_addr), .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata),
    .o_sram_we_n(we_n), .o_sram_oe_n(oe_n), .o_state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    n_rec_start += int'(rec_start);
    n_dsp_start += int'(dsp_start);
    n_dsp_pause += int'(dsp_pause);
    if (we_n === 1'b0 && oe_n === 1'b0) chk("we_oe_overlap", 32'd1, 32'd0);
    if (we_n === 1'b0) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {12'd0, sram_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {12'd0, sram_addr}, {12'd0, e.a});
        chk("wr_data", {16'd0, sram_wdata}, {16'd0, e.d});
      end
    end
  endtask

  task automatic keys_off();
    key_rec = 0; key_play = 0; key_pause = 0; key_stop = 0;
  endtask

  initial begin
    rst = 1; key_rec = 1; key_play = 1; key_pause = 1; key_stop = 1;
    rec_we = 0; rec_addr = '0; rec_data = '0; dsp_addr = '0;
    repeat (3) tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_we_n", {31'd0, we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
    chk("rst_stop_addr", {12'd0, stop_addr}, 32'd0);
    rst = 0; keys_off();
    repeat (3) tick();
    chk("post_rst_state", {29'd0, state}, 32'd0);
    chk("post_rst_starts", n_rec_start + n_dsp_start, 0);

    // Play without a recording is ignored.
    key_play = 1; tick(); keys_off(); tick();
    chk("play_no_rec", {29'd0, state}, 32'd0);

    // Record four samples then stop.
    key_rec = 1; tick(); keys_off();
    chk("rec_turn0", {29'd0, state}, 32'd1);
    tick();
    chk("rec_turn1", {29'd0, state}, 32'd1);
    tick();
    chk("rec_entry", {29'd0, state}, 32'd2);
    chk("rec_start_pulse", {31'd0, rec_start}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      rec_we = 1; rec_addr = 20'(i); rec_data = 16'(16'h1111 * (i + 1));
      exp_q.push_back('{a: 20'(i), d: 16'(16'h1111 * (i + 1))});
      tick();
    end
    rec_we = 0; key_stop = 1; tick(); keys_off();
    chk("rec_strobes", n_strobe, 4);
    chk("rec_stop_addr", {12'd0, stop_addr}, 32'd3);
    chk("rec_stop_state", {29'd0, state}, 32'd0);
    chk("rec_start_count", n_rec_start, 1);

    // Playback: turnaround then a single start pulse with reads enabled.
    dsp_addr = 20'd0;
    key_play = 1; tick(); keys_off();
    chk("play_turn0", {29'd0, state}, 32'd1);
    tick();
    chk("play_turn1", {29'd0, state}, 32'd1);
    chk("play_turn_oe_n", {31'd0, oe_n}, 32'd1);
    tick();
    chk("play_entry", {29'd0, state}, 32'd4);
    chk("play_dsp_start", {31'd0, dsp_start}, 32'd1);
    chk("play_oe_n", {31'd0, oe_n}, 32'd0);
    dsp_addr = 20'd2; tick();
    chk("play_rd_addr", {12'd0, sram_addr}, 32'd2);
    chk("play_single_start", n_dsp_start, 1);
    key_rec = 1; tick(); keys_off();
    chk("play_rec_ignored", {29'd0, state}, 32'd4);

    key_pause = 1; tick(); keys_off();
    chk("pause1_state", {29'd0, state}, 32'd5);
    chk("pause1_pulse", {31'd0, dsp_pause}, 32'd1);
    tick();
    key_pause = 1; tick(); keys_off();
    chk("pause2_state", {29'd0, state}, 32'd4);
    chk("pause_count", n_dsp_pause, 2);
    key_pause = 1; key_stop = 1; tick(); keys_off();
    chk("pause_stop_state", {29'd0, state}, 32'd0);
    chk("pause_stop_no_pulse", n_dsp_pause, 2);
    chk("pause_stop_oe_n", {31'd0, oe_n}, 32'd1);

    // Playback reaching the stop address.
    dsp_addr = 20'd0;
    key_play = 1; tick(); keys_off(); tick(); tick();
    chk("auto_play_entry", {29'd0, state}, 32'd4);
    dsp_addr = 20'd3; tick();
    chk("auto_first_match", {29'd0, state}, 32'd4);
    tick();
`ifdef AUD_SCHED_AUTOSTOP_EN
    chk("auto_stop_state", {29'd0, state}, 32'd0);
`else
    chk("auto_stop_state", {29'd0, state}, 32'd4);
    key_stop = 1; tick(); keys_off();
    chk("manual_stop_state", {29'd0, state}, 32'd0);
`endif

    // Paused recorder ignores writes; stop without a write keeps the old stop address.
    key_rec = 1; tick(); keys_off(); tick(); tick();
    chk("rec2_entry", {29'd0, state}, 32'd2);
    key_pause = 1; tick(); keys_off();
    chk("rec_p_state", {29'd0, state}, 32'd3);
    chk("rec_p_level", {31'd0, rec_pause}, 32'd1);
    rec_we = 1; rec_addr = 20'd9; rec_data = 16'hDEAD; tick(); rec_we = 0;
    chk("rec_p_no_strobe", n_strobe, 4);
    key_pause = 1; tick(); keys_off();
    chk("rec_resume_state", {29'd0, state}, 32'd2);
    chk("rec_resume_level", {31'd0, rec_pause}, 32'd0);
    key_stop = 1; tick(); keys_off();
    chk("rec_nowrite_stop_addr", {12'd0, stop_addr}, 32'd3);
    chk("rec_nowrite_state", {29'd0, state}, 32'd0);

    // Write at the last SRAM word ends recording.
    key_rec = 1; tick(); keys_off(); tick(); tick();
    chk("rec3_entry", {29'd0, state}, 32'd2);
    rec_we = 1; rec_addr = 20'd5; rec_data = 16'hAAAA;
    exp_q.push_back('{a: 20'd5, d: 16'hAAAA});
    tick();
    rec_addr = 20'hFFFFF; rec_data = 16'h5555;
    exp_q.push_back('{a: 20'hFFFFF, d: 16'h5555});
    tick();
    chk("max_stop_addr", {12'd0, stop_addr}, 32'hFFFFF);
    chk("max_state", {29'd0, state}, 32'd0);
    rec_addr = 20'd7; rec_data = 16'h7777; tick(); rec_we = 0;
    chk("max_after_no_strobe", n_strobe, 6);
    chk("max_after_we_n", {31'd0, we_n}, 32'd1);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
